nx1_vram_scan: RTL and testbench
================================

Name: nx1_vram_scan

Overview:
- Video-side reader for the X1 2K×8 text/attribute dual-port RAM.
- Generates the video read address, absorbs the RAM's 1-cycle synchronous read latency, and streams one text row of character codes per request to the character-generator pipeline over a valid/ready handshake.
- Sits in the VCLK domain between the CRTC timing logic (row/frame requests) and the font ROM lookup.

Parameters:
- AW, 11, video address width; the address wraps modulo 2^AW.
- CW, 7, column counter width; supports up to 127 columns (40/80 in use).
- RW, 5, row counter width.

Ports:
- VCLK  in  1  video clock; all logic is on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- FSTART  in  1  frame-start pulse; latches BASE and clears the row counter.
- RSTART  in  1  row-fetch request pulse from the CRTC.
- BASE  in  AW  frame start address; sampled only on FSTART.
- COLS  in  CW  characters per row; sampled on FSTART; 0 is treated as 1.
- ROWS  in  RW  rows per frame; sampled on FSTART; 0 is treated as 1.
- VA  out  AW  RAM read address.
- VDO  in  8  RAM read data; valid 1 VCLK after VA.
- ODATA  out  8  character code of the output beat.
- OCOL  out  CW  column index of ODATA.
- OVALID  out  1  output beat valid.
- OREADY  in  1  downstream accept.
- ROWDONE  out  1  1-cycle pulse when the last column of a row is accepted.
- FRAMEDONE  out  1  level; high once row ROWS-1 completes, cleared by FSTART.
- BUSY  out  1  high while in FETCH or DRAIN.

Behaviour:
- Reset values: VA=0, ODATA=0, OCOL=0, OVALID=0, ROWDONE=0, FRAMEDONE=0, BUSY=0. Internal state is IDLE, buffer empty, row pointer 0, row counter 0.
- FSTART (any state):
  - Latch BASE into the row pointer, and latch COLS and ROWS.
  - Clear the row counter and FRAMEDONE.
  - Abort any row in progress: flush the buffer, clear OVALID, go to IDLE. Same cycle takes priority over RSTART.
- State IDLE:
  - RSTART with FRAMEDONE=0: go to FETCH, set the column issue counter to 0, set VA to the row pointer.
  - RSTART with FRAMEDONE=1 is ignored.
  - RSTART while in FETCH or DRAIN is ignored.
- State FETCH:
  - Issue a read (VA = row pointer + issue column, modulo 2^AW) when (buffered entries + read in flight) < 2.
  - One cycle later, VDO and its column are pushed into the 2-entry output buffer.
  - After column COLS-1 is issued, go to DRAIN.
- State DRAIN:
  - When the buffer is empty and no read is in flight, go to IDLE.
  - In the same cycle, advance the row pointer by the latched COLS (wraps modulo 2^AW) and increment the row counter.
  - If the row counter reaches ROWS-1 at this point, set FRAMEDONE.
- Output handshake:
  - OVALID reflects a non-empty buffer; ODATA/OCOL show the buffer head.
  - A beat transfers when OVALID and OREADY are both high.
  - ODATA/OCOL stay stable while OVALID=1 and OREADY=0.
  - Push and pop in the same cycle are allowed; occupancy never exceeds 2 and no data is lost under any OREADY pattern.
- Throughput: 1 beat/cycle with OREADY held high. First OVALID appears 2 cycles after RSTART (issue, then capture).
- ROWDONE pulses in the cycle the beat with OCOL = COLS-1 transfers.
- VA holds its last value when no read is issued.

Optional Feature:
- NX1_SCAN_ATTR_EN defined:
  - Adds port ADI (in, 8): attribute RAM data, read at the same VA with the same 1-cycle latency.
  - Adds port OATTR (out, 8), buffered alongside ODATA in the same entries with identical handshake semantics.
  - Reset value of OATTR is 0.
- Undefined: neither port exists and the buffer is 8+CW bits wide per entry.

Decomposition:
- Package nx1_scan_pkg holds:
  - State enum: IDLE, FETCH, DRAIN.
  - Buffer depth constant SCAN_BUF_DEPTH=2.
  - Default widths: AW=11, CW=7, RW=5.
- One sub-module, nx1_scan_skid: a 2-entry valid/ready buffer with push/pop/count and a parameterised data width. It is reused for the ODATA/OCOL (and optional OATTR) payload.

Test Plan:
- Basic row: FSTART with BASE=0x000, COLS=40, ROWS=25, then RSTART, OREADY=1.
  - 40 beats, ODATA = RAM[0..39], OCOL 0..39, contiguous.
  - ROWDONE on the OCOL=39 beat; next row starts at 0x028.
- Wrap-around: BASE=0x7F0, COLS=80.
  - VA sequence is 0x7F0..0x7FF, then 0x000..0x03F.
  - Data matches and the next row pointer is 0x040.
- Backpressure: random OREADY at 30% duty.
  - All 80 beats are delivered in order with none dropped or duplicated.
  - Occupancy stays ≤ 2 and ODATA is stable while stalled.
- Frame end: ROWS=2, COLS=4, issue 3 RSTARTs.
  - FRAMEDONE goes high after row 1 completes.
  - The third RSTART produces no VA activity and OVALID stays 0.
- Abort: FSTART during column 10 of a row.
  - OVALID goes to 0 next cycle, the state returns to IDLE, and BASE is reloaded.
  - A following RSTART fetches from the new BASE.
- Async reset mid-row: assert RESET between edges.
  - All outputs are immediately at their reset values.
  - After release, FSTART+RSTART operate normally.

Source files
------------

// File: rtl/nx1_scan_pkg.sv
// nx1_scan_pkg: shared state type, buffer depth and default widths for the X1 video RAM scanner.
package nx1_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } scan_state_t;

    localparam int SCAN_BUF_DEPTH = 2;
    localparam int SCAN_AW        = 11;
    localparam int SCAN_CW        = 7;
    localparam int SCAN_RW        = 5;

endpackage

// File: rtl/nx1_scan_skid.sv
// nx1_scan_skid: 2-entry valid/ready buffer; the head entry drives the output directly.
module nx1_scan_skid
    import nx1_scan_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] din,
    input  logic          pop,
    output logic [DW-1:0] dout,
    output logic          valid,
    output logic [1:0]    count
);

    logic [DW-1:0] head;
    logic [DW-1:0] tail;
    logic          do_pop;
    logic          do_push;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count < 2'(SCAN_BUF_DEPTH)) || do_pop);

    // The head only moves on a pop or on a push into an empty buffer,
    // so the output holds steady while the consumer stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= 2'd0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({do_push, do_pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head <= tail;
                        tail <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dout  = head;
    assign valid = (count != 2'd0);

endmodule

// File: rtl/nx1_vram_scan.sv
// nx1_vram_scan: streams one text row of character codes from the X1 text RAM per row request.
// Define NX1_SCAN_ATTR_EN to also fetch and stream the attribute byte (adi/oattr).
module nx1_vram_scan
    import nx1_scan_pkg::*;
#(
    parameter int AW = SCAN_AW,
    parameter int CW = SCAN_CW,
    parameter int RW = SCAN_RW
) (
    input  logic          vclk,
    input  logic          reset,
    input  logic          fstart,
    input  logic          rstart,
    input  logic [AW-1:0] base,
    input  logic [CW-1:0] cols,
    input  logic [RW-1:0] rows,
    output logic [AW-1:0] va,
    input  logic [7:0]    vdo,
`ifdef NX1_SCAN_ATTR_EN
    input  logic [7:0]    adi,
    output logic [7:0]    oattr,
`endif
    output logic [7:0]    odata,
    output logic [CW-1:0] ocol,
    output logic          ovalid,
    input  logic          oready,
    output logic          rowdone,
    output logic          framedone,
    output logic          busy
);

`ifdef NX1_SCAN_ATTR_EN
    localparam int PW = 16 + CW;
`else
    localparam int PW = 8 + CW;
`endif

    scan_state_t   state;
    logic [AW-1:0] row_ptr;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] cols_l;
    logic [RW-1:0] rows_l;
    logic [CW-1:0] issue_col;
    logic [CW-1:0] rd_col;
    logic [CW-1:0] last_col;
    logic          rd_pend;
    logic          pop;
    logic          can_issue;
    logic [2:0]    occ;
    logic [1:0]    buf_count;
    logic [PW-1:0] push_data;
    logic [PW-1:0] head;

`ifdef NX1_SCAN_ATTR_EN
    assign push_data = {adi, rd_col, vdo};
    assign oattr     = head[8+CW +: 8];
`else
    assign push_data = {rd_col, vdo};
`endif

    assign odata    = head[7:0];
    assign ocol     = head[8 +: CW];
    assign last_col = cols_l - CW'(1);
    assign pop      = ovalid && oready;
    assign rowdone  = pop && (ocol == last_col);
    assign busy     = (state != IDLE);

    // Credit counts the slot freed by this cycle's pop, which is what sustains one beat per cycle.
    assign occ       = {1'b0, buf_count} + {2'b00, rd_pend} - {2'b00, pop};
    assign can_issue = (occ < 3'd2);

    nx1_scan_skid #(
        .DW(PW)
    ) u_skid (
        .clock (vclk),
        .reset (reset),
        .flush (fstart),
        .push  (rd_pend),
        .din   (push_data),
        .pop   (pop),
        .dout  (head),
        .valid (ovalid),
        .count (buf_count)
    );

    // Row sequencer; a frame start overrides everything and drops any read still in flight.
    always_ff @(posedge vclk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            va        <= '0;
            row_ptr   <= '0;
            row_cnt   <= '0;
            cols_l    <= CW'(1);
            rows_l    <= RW'(1);
            framedone <= 1'b0;
            issue_col <= '0;
            rd_pend   <= 1'b0;
            rd_col    <= '0;
        end else if (fstart) begin
            state     <= IDLE;
            row_ptr   <= base;
            cols_l    <= (cols == '0) ? CW'(1) : cols;
            rows_l    <= (rows == '0) ? RW'(1) : rows;
            row_cnt   <= '0;
            framedone <= 1'b0;
            rd_pend   <= 1'b0;
        end else begin
            rd_pend <= 1'b0;
            case (state)
                IDLE: begin
                    if (rstart && !framedone) begin
                        va      <= row_ptr;
                        rd_pend <= 1'b1;
                        rd_col  <= '0;
                        if (cols_l == CW'(1)) begin
                            state <= DRAIN;
                        end else begin
                            state     <= FETCH;
                            issue_col <= CW'(1);
                        end
                    end
                end
                FETCH: begin
                    if (can_issue) begin
                        va      <= row_ptr + AW'(issue_col);
                        rd_pend <= 1'b1;
                        rd_col  <= issue_col;
                        if (issue_col == last_col) state <= DRAIN;
                        else                       issue_col <= issue_col + CW'(1);
                    end
                end
                DRAIN: begin
                    if (!ovalid && !rd_pend) begin
                        state   <= IDLE;
                        row_ptr <= row_ptr + AW'(cols_l);
                        row_cnt <= row_cnt + RW'(1);
                        if (row_cnt == rows_l - RW'(1)) framedone <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nx1_vram_scan.sv
// tb_nx1_vram_scan: randomized row fetches against a RAM image and pointer model of the scanner.
module tb_nx1_vram_scan;

    logic        vclk;
    logic        reset;
    logic        fstart;
    logic        rstart;
    logic [10:0] base;
    logic [6:0]  cols;
    logic [4:0]  rows;
    logic [10:0] va;
    logic [7:0]  vdo;
    logic [7:0]  odata;
    logic [6:0]  ocol;
    logic        ovalid;
    logic        oready;
    logic        rowdone;
    logic        framedone;
    logic        busy;

    logic [7:0]  ram [0:2047];
`ifdef NX1_SCAN_ATTR_EN
    logic [7:0]  aram [0:2047];
    logic [7:0]  adi;
    logic [7:0]  oattr;
    assign adi = aram[va];
`endif

    // Read data for the address presented on the previous edge.
    assign vdo = ram[va];

    int          total;
    int          bad;
    logic [10:0] m_ptr;
    int          m_cols;
    int          m_rows;
    int          m_rows_done;

    nx1_vram_scan dut (
        .vclk      (vclk),
        .reset     (reset),
        .fstart    (fstart),
        .rstart    (rstart),
        .base      (base),
        .cols      (cols),
        .rows      (rows),
        .va        (va),
        .vdo       (vdo),
`ifdef NX1_SCAN_ATTR_EN
        .adi       (adi),
        .oattr     (oattr),
`endif
        .odata     (odata),
        .ocol      (ocol),
        .ovalid    (ovalid),
        .oready    (oready),
        .rowdone   (rowdone),
        .framedone (framedone),
        .busy      (busy)
    );

    initial begin
        vclk = 1'b0;
        forever #5 vclk = ~vclk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // Frame start: drive the new frame parameters and reset the reference pointer model.
    task automatic applyStimulus(input logic [10:0] b, input int c, input int r);
        base   = b;
        cols   = 7'(c);
        rows   = 5'(r);
        fstart = 1'b1;
        @(posedge vclk);
        #1;
        fstart      = 1'b0;
        m_ptr       = b;
        m_cols      = (c == 0) ? 1 : c;
        m_rows      = (r == 0) ? 1 : r;
        m_rows_done = 0;
    endtask

    // One row request; expected beats are RAM[(ptr + col) mod 2048] for col = 0..cols-1.
    task automatic doRow(input int duty, input int stop_after);
        int          got;
        int          iter;
        int          first_valid;
        int          last_xfer;
        int          budget;
        logic [10:0] va_log [$];
        logic [10:0] last_va;
        logic [10:0] addr;
        logic        prev_stall;
        logic        xfer;
        logic        stopped;
        logic [14:0] prev_beat;
        got = 0; iter = 0; first_valid = -1; last_xfer = -1; stopped = 1'b0;
        prev_stall = 1'b0; prev_beat = '0; budget = m_cols * 40 + 50;
        rstart = 1'b1;
        @(posedge vclk);
        #1;
        rstart  = 1'b0;
        last_va = va;
        va_log.push_back(va);
        forever begin
            if (va != last_va) begin
                last_va = va;
                va_log.push_back(va);
            end
            if (prev_stall) checkOutput("stall_hold", {ovalid, ocol, odata}, {1'b1, prev_beat});
            oready = ($urandom_range(99) < duty);
            #1;
            if (ovalid && first_valid < 0) first_valid = iter;
            xfer = ovalid && oready;
            checkOutput("rowdone", rowdone, xfer && (got == m_cols - 1));
            if (xfer) begin
                addr = m_ptr + 11'(got);
                checkOutput("ocol", ocol, got);
                checkOutput("odata", odata, ram[addr]);
`ifdef NX1_SCAN_ATTR_EN
                checkOutput("oattr", oattr, aram[addr]);
`endif
                got++;
                last_xfer = iter;
            end
            prev_stall = ovalid && !oready;
            prev_beat  = {ocol, odata};
            if (stop_after >= 0 && got == stop_after) begin
                stopped = 1'b1;
                break;
            end
            @(posedge vclk);
            #1;
            iter++;
            if (!busy && !ovalid) break;
            if (iter > budget) begin
                checkOutput("row_timeout", {busy, ovalid}, 0);
                break;
            end
        end
        if (!stopped) begin
            checkOutput("beats", got, m_cols);
            checkOutput("va_count", va_log.size(), m_cols);
            for (int i = 0; i < va_log.size() && i < m_cols; i++) begin
                addr = m_ptr + 11'(i);
                checkOutput("va_seq", va_log[i], addr);
            end
            checkOutput("first_valid", first_valid, 1);
            if (duty >= 100) checkOutput("full_rate", last_xfer, m_cols);
            m_ptr = m_ptr + 11'(m_cols);
            m_rows_done++;
            checkOutput("framedone", framedone, m_rows_done >= m_rows);
        end
    endtask

    initial begin
        logic [10:0] saved_va;
        total = 0; bad = 0;
        reset = 1'b0; fstart = 1'b0; rstart = 1'b0;
        base = '0; cols = '0; rows = '0; oready = 1'b0;
        m_ptr = '0; m_cols = 1; m_rows = 1; m_rows_done = 0;
        for (int i = 0; i < 2048; i++) begin
            ram[i] = 8'($urandom);
`ifdef NX1_SCAN_ATTR_EN
            aram[i] = 8'($urandom);
`endif
        end
        #1 reset = 1'b1;
        #2;
        checkOutput("reset_state", {va, odata, ocol, ovalid, rowdone, framedone, busy}, 0);
        @(posedge vclk);
        #3 reset = 1'b0;
        @(posedge vclk);
        #1;

        $display("[TB] basic row and next-row pointer");
        applyStimulus(11'h000, 40, 25);
        doRow(100, -1);
        doRow(100, -1);

        $display("[TB] address wrap-around");
        applyStimulus(11'h7F0, 80, 25);
        doRow(100, -1);
        doRow(100, -1);

        $display("[TB] backpressure");
        applyStimulus(11'($urandom), 80, 25);
        doRow(30, -1);
        doRow(30, -1);

        $display("[TB] frame end");
        applyStimulus(11'($urandom), 4, 2);
        doRow(100, -1);
        doRow(100, -1);
        saved_va = va;
        rstart = 1'b1;
        @(posedge vclk);
        #1;
        rstart = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checkOutput("ignored_rstart", {va, ovalid, busy}, {saved_va, 2'b00});
            @(posedge vclk);
            #1;
        end

        $display("[TB] zero cols and rows");
        applyStimulus(11'h123, 0, 0);
        doRow(70, -1);

        $display("[TB] abort by frame start");
        applyStimulus(11'h100, 40, 25);
        oready = 1'b1;
        doRow(100, 10);
        applyStimulus(11'h555, 40, 25);
        checkOutput("abort_ovalid", ovalid, 0);
        checkOutput("abort_busy", busy, 0);
        doRow(100, -1);

        $display("[TB] async reset mid-row");
        applyStimulus(11'h300, 40, 25);
        doRow(100, 5);
        reset = 1'b1;
        #1;
        checkOutput("reset_mid", {va, odata, ocol, ovalid, rowdone, framedone, busy}, 0);
        #20 reset = 1'b0;
        @(posedge vclk);
        #1;
        applyStimulus(11'h234, 40, 25);
        doRow(50, -1);

        $display("[TB] random rows");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(11'($urandom), int'($urandom_range(1, 100)), 25);
            doRow(int'($urandom_range(20, 100)), -1);
            doRow(int'($urandom_range(20, 100)), -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
